// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: requester indices, sizing and the
// read-return tag carried alongside each in-flight SRAM read.
package sram_arbiter_pkg;

   localparam int NUM_REQ      = 3;
   localparam int READ_LATENCY = 2;
   localparam int IDX_W        = 2;

   typedef enum logic [IDX_W-1:0] {
      REQ_FETCH  = 2'd0,
      REQ_RGB_WR = 2'd1,
      REQ_DISP   = 2'd2
   } req_idx_e;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } rd_tag_t;

endpackage

// File: rtl/sram_arbiter_rr_select.sv
// Rotating-priority search: grants the first requester at or after start_i,
// wrapping modulo N. Purely combinational.
module rr_select #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] start_i,
   output logic [N-1:0] gnt_o
);

   logic [W:0] idx;
   logic       found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, start_i} + (W+1)'(k);
         if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
         if (!found && req_i[idx[W-1:0]]) begin
            gnt_o[idx[W-1:0]] = 1'b1;
            found             = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between NUM_REQ requesters,
// with lock support and a tag pipeline that routes read data back to its owner.
module sram_arbiter #(
   parameter int NUM_REQ      = sram_arbiter_pkg::NUM_REQ,
   parameter int READ_LATENCY = sram_arbiter_pkg::READ_LATENCY
) (
   input  logic                     Clock_50,
   input  logic                     Reset,
   input  logic                     SRAM_ready,
   input  logic [NUM_REQ-1:0]       Req,
   input  logic [NUM_REQ-1:0]       Req_we_n,
   input  logic [NUM_REQ-1:0]       Req_lock,
   input  logic [NUM_REQ-1:0][17:0] Req_address,
   input  logic [NUM_REQ-1:0][15:0] Req_write_data,
   output logic [NUM_REQ-1:0]       Gnt,
   output logic [NUM_REQ-1:0]       Rd_valid,
   output logic [15:0]              Rd_data,
   output logic [17:0]              SRAM_address,
   output logic [15:0]              SRAM_write_data,
   output logic                     SRAM_we_n,
   input  logic [15:0]              SRAM_read_data
);

   import sram_arbiter_pkg::*;

   localparam int IW = $clog2(NUM_REQ);

   logic [IW-1:0]      last_q, last_d, start;
   logic [NUM_REQ-1:0] rr_gnt, gnt, rd_valid_q, rd_valid_d;
   logic               accept;
   logic [IW-1:0]      acc_idx;
   logic [17:0]        addr_q, addr_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               we_n_q, we_n_d;
   rd_tag_t            new_tag;
   rd_tag_t [READ_LATENCY-1:0] tag_q, tag_d;

   always_comb start = (last_q == IW'(NUM_REQ-1)) ? '0 : last_q + 1'b1;

   rr_select #(.N(NUM_REQ), .W(IW)) u_rr_select (
      .req_i   (Req),
      .start_i (start),
      .gnt_o   (rr_gnt)
   );

   // A held lock pins the grant to the previous winner until it drops Req.
   always_comb begin
      gnt = '0;
      if (!Reset && SRAM_ready) begin
         if (Req_lock[last_q] && Req[last_q]) gnt[last_q] = 1'b1;
         else                                 gnt = rr_gnt;
      end
   end

   always_comb begin
      accept  = 1'b0;
      acc_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i] && Req[i]) begin
            accept  = 1'b1;
            acc_idx = IW'(i);
         end
      end
   end

   always_comb begin
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_n_d  = 1'b1;
      new_tag = '0;
      if (accept) begin
         last_d        = acc_idx;
         addr_d        = Req_address[acc_idx];
         wdata_d       = Req_write_data[acc_idx];
         we_n_d        = Req_we_n[acc_idx];
         new_tag.valid = Req_we_n[acc_idx];
         new_tag.idx   = IDX_W'(acc_idx);
      end
   end

   generate
      for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
         if (gi == 0) begin : g_head
            assign tag_d[gi] = new_tag;
         end else begin : g_body
            assign tag_d[gi] = tag_q[gi-1];
         end
      end
   endgenerate

   // Strobe is registered so it lands in the cycle after the data-valid edge.
   always_comb begin
      rd_valid_d = '0;
      if (tag_q[READ_LATENCY-1].valid) rd_valid_d[tag_q[READ_LATENCY-1].idx] = 1'b1;
   end

   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         last_q     <= IW'(NUM_REQ-1);
         addr_q     <= '0;
         wdata_q    <= '0;
         we_n_q     <= 1'b1;
         tag_q      <= '0;
         rd_valid_q <= '0;
      end else begin
         last_q     <= last_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_n_q     <= we_n_d;
         tag_q      <= tag_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign Gnt             = gnt;
   assign Rd_valid        = rd_valid_q;
   assign Rd_data         = SRAM_read_data;
   assign SRAM_address    = addr_q;
   assign SRAM_write_data = wdata_q;
   assign SRAM_we_n       = we_n_q;

endmodule
